xor_check_monitor: RTL and testbench

XOR_CHECK_MONITOR -- requirements
Module: xor_check_monitor

---
 rtl/xor_check_pkg.sv | 12 +
 rtl/sat_counter.sv | 33 +++
 rtl/xor_check_monitor.sv | 104 ++++++++++
 tb/tb_xor_check_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_check_pkg.sv
// Shared types and constants for the XOR gate check monitor.
package xor_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FAIL_VEC_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its maximum value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/xor_check_monitor.sv
// Compares a gate under test against a golden gate over a session of samples,
// tallying pass/fail, recording the first failure and tracking input coverage.
module xor_check_monitor
  import xor_check_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int NUM_TESTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  in_a,
  input  logic                  in_b,
  input  logic                  dut_out,
  input  logic                  ref_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      test_count,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      fail_count,
  output logic                  error,
  output logic [FAIL_VEC_W-1:0] first_fail_vec,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [3:0]            coverage,
  output logic                  cover_all
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TESTS - 1);

  state_e                  state_q, state_d;
  logic                    error_q, error_d;
  logic [FAIL_VEC_W-1:0]   failVec_q, failVec_d;
  logic [CNT_W-1:0]        failIdx_q, failIdx_d;
  logic [3:0]              cov_q, cov_d;
  logic                    accept;
  logic                    mismatch;

  assign accept   = (state_q == RUN) && sample_valid && !start;
  // Case-inequality so that an X or Z on either gate output is a failure.
  assign mismatch = (dut_out !== ref_out);

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    failVec_d = failVec_q;
    failIdx_d = failIdx_q;
    cov_d     = cov_q;
    if (start) begin
      state_d   = RUN;
      error_d   = 1'b0;
      failVec_d = '0;
      failIdx_d = '0;
      cov_d     = '0;
    end else if (accept) begin
      cov_d[{in_a, in_b}] = 1'b1;
      if (mismatch && !error_q) begin
        error_d   = 1'b1;
        failVec_d = {in_a, in_b, dut_out, ref_out};
        failIdx_d = test_count;
      end
      if (test_count == LAST_IDX) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      error_q   <= 1'b0;
      failVec_q <= '0;
      failIdx_q <= '0;
      cov_q     <= '0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      failVec_q <= failVec_d;
      failIdx_q <= failIdx_d;
      cov_q     <= cov_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_test_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start), .en_i(accept), .count_o(test_count)
  );

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start), .en_i(accept && !mismatch), .count_o(pass_count)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start), .en_i(accept && mismatch), .count_o(fail_count)
  );

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign error          = error_q;
  assign first_fail_vec = failVec_q;
  assign first_fail_idx = failIdx_q;
  assign coverage       = cov_q;
  assign cover_all      = &cov_q;

endmodule

// File: tb/tb_xor_check_monitor.sv
// Self-checking bench: directed scenarios plus a randomized run against a session-level model.
module tb_xor_check_monitor;

  localparam int NUM = 4;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, sampleValid = 1'b0;
  logic inA = 1'b0, inB = 1'b0, dutOut = 1'b0, refOut = 1'b0;
  logic busy, done, error, coverAll;
  logic [7:0] testCount, passCount, failCount, firstFailIdx;
  logic [3:0] firstFailVec, coverage;

  logic sRst = 1'b1, sStart = 1'b0, sValid = 1'b0;
  logic sA = 1'b0, sB = 1'b0, sDut = 1'b0, sRef = 1'b0;
  logic sBusy, sDone, sError, sCoverAll;
  logic [1:0] sTest, sPass, sFail, sIdx;
  logic [3:0] sVec, sCov;

  int nCompared = 0;
  int nMismatched = 0;

  // Session-level reference model
  int mState = 0;
  int mTest = 0, mPass = 0, mFail = 0, mIdx = 0;
  bit mErr = 1'b0;
  logic [3:0] mVec = 4'b0, mCov = 4'b0;

  always #5 clk = ~clk;

  xor_check_monitor dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sampleValid),
    .in_a(inA), .in_b(inB), .dut_out(dutOut), .ref_out(refOut),
    .busy(busy), .done(done), .test_count(testCount), .pass_count(passCount),
    .fail_count(failCount), .error(error), .first_fail_vec(firstFailVec),
    .first_fail_idx(firstFailIdx), .coverage(coverage), .cover_all(coverAll)
  );

  xor_check_monitor #(.CNT_W(2), .NUM_TESTS(3)) dutSat (
    .clk(clk), .rst(sRst), .start(sStart), .sample_valid(sValid),
    .in_a(sA), .in_b(sB), .dut_out(sDut), .ref_out(sRef),
    .busy(sBusy), .done(sDone), .test_count(sTest), .pass_count(sPass),
    .fail_count(sFail), .error(sError), .first_fail_vec(sVec),
    .first_fail_idx(sIdx), .coverage(sCov), .cover_all(sCoverAll)
  );

  task automatic modelStep(input logic r, s, v, a, b, d, rf);
    if (r) begin
      mState = 0; mTest = 0; mPass = 0; mFail = 0; mIdx = 0;
      mErr = 1'b0; mVec = 4'b0; mCov = 4'b0;
    end else if (s) begin
      mState = 1; mTest = 0; mPass = 0; mFail = 0; mIdx = 0;
      mErr = 1'b0; mVec = 4'b0; mCov = 4'b0;
    end else if (mState == 1 && v) begin
      if (d !== rf) begin
        if (!mErr) begin
          mErr = 1'b1;
          mVec = {a, b, d, rf};
          mIdx = mTest;
        end
        mFail = (mFail + 1 > MAXV) ? MAXV : mFail + 1;
      end else begin
        mPass = (mPass + 1 > MAXV) ? MAXV : mPass + 1;
      end
      mTest = (mTest + 1 > MAXV) ? MAXV : mTest + 1;
      mCov[{a, b}] = 1'b1;
      if (mTest == NUM) mState = 2;
    end
  endtask

  task automatic applyStimulus(input logic r, s, v, a, b, d, rf);
    rst = r; start = s; sampleValid = v;
    inA = a; inB = b; dutOut = d; refOut = rf;
    @(posedge clk);
    modelStep(r, s, v, a, b, d, rf);
    #1;
  endtask

  task automatic goodSample(input logic a, b);
    applyStimulus(1'b0, 1'b0, 1'b1, a, b, a ^ b, a ^ b);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b error=%b want 0 0 0", busy, done, error);
    end
    nCompared++;
    if ({testCount, passCount, failCount, firstFailIdx} !== 32'h0 || firstFailVec !== 4'h0 || coverage !== 4'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_regs got test=%0d pass=%0d fail=%0d idx=%0d vec=%b cov=%b want all 0",
               testCount, passCount, failCount, firstFailIdx, firstFailVec, coverage);
    end
  endtask

  task automatic test_exhaustive();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (busy !== 1'b1 || testCount !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL start_opens got busy=%b test=%0d want busy=1 test=0", busy, testCount);
    end
    goodSample(1'b0, 1'b0);
    nCompared++;
    if (testCount !== 8'd1 || passCount !== 8'd1 || coverage !== 4'b0001) begin
      nMismatched++;
      $display("[TB] FAIL first_latency got test=%0d pass=%0d cov=%b want 1 1 0001", testCount, passCount, coverage);
    end
    goodSample(1'b0, 1'b1);
    goodSample(1'b1, 1'b0);
    goodSample(1'b1, 1'b1);
    nCompared++;
    if (done !== 1'b1 || busy !== 1'b0 || testCount !== 8'd4 || passCount !== 8'd4 || failCount !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL exhaustive_counts got done=%b busy=%b test=%0d pass=%0d fail=%0d want 1 0 4 4 0",
               done, busy, testCount, passCount, failCount);
    end
    nCompared++;
    if (error !== 1'b0 || coverage !== 4'b1111 || coverAll !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL exhaustive_cov got error=%b cov=%b all=%b want 0 1111 1", error, coverage, coverAll);
    end
  endtask

  task automatic test_single_fail();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goodSample(1'b0, 1'b0);
    goodSample(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    goodSample(1'b1, 1'b1);
    nCompared++;
    if (failCount !== 8'd1 || passCount !== 8'd3 || error !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL single_counts got fail=%0d pass=%0d error=%b want 1 3 1", failCount, passCount, error);
    end
    nCompared++;
    if (firstFailVec !== 4'b1001 || firstFailIdx !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL single_capture got vec=%b idx=%0d want 1001 2", firstFailVec, firstFailIdx);
    end
  endtask

  task automatic test_x_input();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'bx, 1'b1);
    nCompared++;
    if (failCount !== 8'd1 || error !== 1'b1 || passCount !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL x_input got fail=%0d pass=%0d error=%b want 1 0 1", failCount, passCount, error);
    end
  endtask

  task automatic test_two_fail();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goodSample(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    goodSample(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nCompared++;
    if (firstFailIdx !== 8'd1 || firstFailVec !== 4'b0101 || failCount !== 8'd2 || passCount !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL two_fail got idx=%0d vec=%b fail=%0d pass=%0d want 1 0101 2 2",
               firstFailIdx, firstFailVec, failCount, passCount);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (testCount !== 8'd0 || busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL collision got test=%0d busy=%b want 0 1", testCount, busy);
    end
    goodSample(1'b1, 1'b1);
    goodSample(1'b1, 1'b0);
    goodSample(1'b0, 1'b1);
    goodSample(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'(i >> 1), 1'(i), 1'b1, 1'b0);
    end
    nCompared++;
    if (testCount !== 8'd4 || passCount !== 8'd4 || failCount !== 8'd0 || done !== 1'b1 || error !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL after_done got test=%0d pass=%0d fail=%0d done=%b error=%b want 4 4 0 1 0",
               testCount, passCount, failCount, done, error);
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goodSample(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || testCount !== 8'd0 || passCount !== 8'd0 ||
        failCount !== 8'd0 || firstFailIdx !== 8'd0 || firstFailVec !== 4'd0 || coverage !== 4'd0) begin
      nMismatched++;
      $display("[TB] FAIL mid_reset got busy=%b done=%b err=%b test=%0d pass=%0d fail=%0d idx=%0d vec=%b cov=%b want all 0",
               busy, done, error, testCount, passCount, failCount, firstFailIdx, firstFailVec, coverage);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) goodSample(1'(i >> 1), 1'(i));
    nCompared++;
    if (testCount !== 8'd4 || done !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL restart got test=%0d done=%b want 4 1", testCount, done);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    sRst = 1'b0; sStart = 1'b1;
    @(posedge clk); #1;
    sStart = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sValid = 1'b1; sA = 1'(i); sB = 1'(i >> 1); sDut = sA ^ sB; sRef = sA ^ sB;
      @(posedge clk); #1;
      if (i == 2) begin
        nCompared++;
        if (sDone !== 1'b1 || sBusy !== 1'b0 || sTest !== 2'd3) begin
          nMismatched++;
          $display("[TB] FAIL sat_done got done=%b busy=%b test=%0d want 1 0 3", sDone, sBusy, sTest);
        end
      end
    end
    sValid = 1'b0;
    nCompared++;
    if (sTest !== 2'd3 || sPass !== 2'd3 || sFail !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL sat_hold got test=%0d pass=%0d fail=%0d want 3 3 0", sTest, sPass, sFail);
    end
  endtask

  task automatic test_random();
    logic r, s, v, a, b, bad, rf;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 9) < 7);
      a   = 1'($urandom);
      b   = 1'($urandom);
      bad = ($urandom_range(0, 6) == 0);
      rf  = a ^ b;
      applyStimulus(r, s, v, a, b, rf ^ bad, rf);
      nCompared++;
      if (busy !== (mState == 1) || done !== (mState == 2) || error !== mErr) begin
        nMismatched++;
        $display("[TB] FAIL rand_flags cycle %0d got busy=%b done=%b err=%b want %b %b %b",
                 i, busy, done, error, (mState == 1), (mState == 2), mErr);
      end
      nCompared++;
      if (testCount !== 8'(mTest) || passCount !== 8'(mPass) || failCount !== 8'(mFail)) begin
        nMismatched++;
        $display("[TB] FAIL rand_counts cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, testCount, passCount, failCount, mTest, mPass, mFail);
      end
      nCompared++;
      if (firstFailVec !== mVec || firstFailIdx !== 8'(mIdx) || coverage !== mCov || coverAll !== (&mCov)) begin
        nMismatched++;
        $display("[TB] FAIL rand_capture cycle %0d got vec=%b idx=%0d cov=%b all=%b want %b %0d %b %b",
                 i, firstFailVec, firstFailIdx, coverage, coverAll, mVec, mIdx, mCov, &mCov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_single_fail();
    test_x_input();
    test_two_fail();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
